// File: rtl/ad9361_tx_feeder.sv
`timescale 1ns/1ps
// ad9361_tx_feeder: transmit sample FIFO feeding the AD9361 1T1R interface.
// Stream words are buffered, primed to a threshold, then popped one I/Q pair
// per tx_ce slot. Empty slots are zero-filled and counted as underruns.
module ad9361_tx_feeder #(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned PRIME_LEVEL = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  tx_ce,
  output logic [11:0]           tx_I,
  output logic [11:0]           tx_Q,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  running,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic [15:0]           underrun_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          full_c;
  logic          empty_c;
  logic          wr_en_c;
  logic          rd_en_c;
  logic          urun_ev_c;
  logic [23:0]   head_c;
  logic          unused_bits;

  // Nibbles between the 12-bit I/Q fields carry no information
  assign unused_bits = ^{s_tdata[31:28], s_tdata[15:12]};

  // Handshake and slot decode from current state and occupancy
  always_comb begin
    full_c    = (fifo_level == LW'(DEPTH));
    empty_c   = (fifo_level == '0);
    s_tready  = (state != IDLE) && !full_c;
    wr_en_c   = s_tvalid && s_tready;
    rd_en_c   = (state == RUN) && en && tx_ce && !empty_c;
    urun_ev_c = (state == RUN) && en && tx_ce && empty_c;
    head_c    = mem[rd_ptr];
  end

  // Sample storage, {Q, I}; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= {s_tdata[27:16], s_tdata[11:0]};
    end
  end

  // Control state, FIFO pointers/level and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      tx_I       <= '0;
      tx_Q       <= '0;
    end else if (!en) begin
      state      <= IDLE;
      running    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      tx_I       <= '0;
      tx_Q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= PRIME;
          running <= 1'b0;
          tx_I    <= '0;
          tx_Q    <= '0;
        end
        PRIME: begin
          tx_I <= '0;
          tx_Q <= '0;
          // Threshold uses occupancy before this edge's write
          if (fifo_level >= LW'(PRIME_LEVEL)) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          running <= 1'b1;
          if (rd_en_c) begin
            tx_I <= head_c[11:0];
            tx_Q <= head_c[23:12];
          end else if (urun_ev_c) begin
            tx_I <= '0;
            tx_Q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({wr_en_c, rd_en_c})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky underrun flag and saturating counter; a new underrun beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (urun_ev_c) begin
      underrun <= 1'b1;
      if (underrun_clr) begin
        underrun_cnt <= 16'd1;
      end else if (underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end else if (underrun_clr) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ad9361_tx_feeder.sv
`timescale 1ns/1ps
// Bench for ad9361_tx_feeder: queue-based model plus per-cycle compare.
module tb_ad9361_tx_feeder;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned PRIMEL = 256;
  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        tx_ce = 1'b0;
  logic [11:0] tx_I;
  logic [11:0] tx_Q;
  logic [9:0]  fifo_level;
  logic        running;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model state
  int          m_mode = M_IDLE;
  logic [31:0] q[$];
  logic [11:0] m_i = '0;
  logic [11:0] m_q = '0;
  logic        m_ur = 1'b0;
  logic [15:0] m_cnt = '0;

  ad9361_tx_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .tx_ce        (tx_ce),
    .tx_I         (tx_I),
    .tx_Q         (tx_Q),
    .fifo_level   (fifo_level),
    .running      (running),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of accepted words, mode, slot outcomes
  always @(posedge clk) begin
    int          sz;
    bit          ev;
    bit          rdy;
    logic [31:0] w;
    if (rst) begin
      m_mode = M_IDLE;
      q.delete();
      m_i = '0;
      m_q = '0;
      m_ur = 1'b0;
      m_cnt = '0;
    end else begin
      sz  = q.size();
      rdy = (m_mode != M_IDLE) && (sz < DEPTH);
      ev  = 1'b0;
      if (!en) begin
        m_mode = M_IDLE;
        q.delete();
        m_i = '0;
        m_q = '0;
      end else begin
        if (m_mode == M_RUN && tx_ce) begin
          if (sz != 0) begin
            w = q.pop_front();
            m_i = w[11:0];
            m_q = w[27:16];
          end else begin
            m_i = '0;
            m_q = '0;
            ev = 1'b1;
          end
        end
        if (s_tvalid && rdy) q.push_back(s_tdata);
        if (m_mode == M_IDLE) m_mode = M_PRIME;
        else if (m_mode == M_PRIME && sz >= PRIMEL) m_mode = M_RUN;
      end
      if (ev) begin
        m_ur = 1'b1;
        if (underrun_clr) m_cnt = 16'd1;
        else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (underrun_clr) begin
        m_ur = 1'b0;
        m_cnt = '0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("tx_I", 32'(tx_I), 32'(m_i));
      check("tx_Q", 32'(tx_Q), 32'(m_q));
      check("fifo_level", 32'(fifo_level), 32'(q.size()));
      check("running", 32'(running), 32'(m_mode == M_RUN));
      check("s_tready", 32'(s_tready), 32'((m_mode != M_IDLE) && (q.size() < DEPTH)));
      check("underrun", 32'(underrun), 32'(m_ur));
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic ce,
                       input logic e, input logic clr);
    s_tvalid     = v;
    s_tdata      = d;
    tx_ce        = ce;
    en           = e;
    underrun_clr = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic rnd_cycle(input int pv, input int pc, input int pclr);
    drive(1'($urandom_range(0, 99) < pv), $urandom, 1'($urandom_range(0, 99) < pc),
          1'b1, 1'($urandom_range(0, 99) < pclr));
  endtask

  task automatic drain();
    for (int k = 0; k < 1200 && q.size() != 0; k++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_on = 1'b1;
    check("rst_txI", 32'(tx_I), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    rst = 1'b0;

    // Enable and prime with I=n, Q=0x800|n
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 256; n++)
      drive(1'b1, {4'hF, 12'h800 | 12'(n), 4'hA, 12'(n)}, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("prime_level", 32'(fifo_level), 32'd256);
    check("prime_not_run", 32'(running), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("run_rise", 32'(running), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("first_I", 32'(tx_I), 32'd0);
    check("first_Q", 32'(tx_Q), 32'h800);
    check("first_level", 32'(fifo_level), 32'd255);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("second_I", 32'(tx_I), 32'd1);
    check("second_Q", 32'(tx_Q), 32'h801);

    // Fill to full with valid held high, then one pop
    repeat (300) drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    check("full_level", 32'(fifo_level), 32'd512);
    check("full_tready", 32'(s_tready), 32'd0);
    drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    check("pop_tready", 32'(s_tready), 32'd1);
    drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    check("refill_level", 32'(fifo_level), 32'd512);

    // Random traffic, enough words to wrap pointers several times
    repeat (1500) rnd_cycle(55, 45, 2);

    // Drain, clear, then three empty slots
    drain();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("clr_flag", 32'(underrun), 32'd0);
    repeat (3) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    check("ur_flag", 32'(underrun), 32'd1);
    check("ur_cnt3", 32'(underrun_cnt), 32'd3);
    check("ur_I", 32'(tx_I), 32'd0);
    check("ur_Q", 32'(tx_Q), 32'd0);

    // Resume
    repeat (200) rnd_cycle(60, 40, 0);
    check("still_run", 32'(running), 32'd1);

    // Clear colliding with an underrun, then clear alone
    drain();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("clrset_flag", 32'(underrun), 32'd1);
    check("clrset_cnt", 32'(underrun_cnt), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("clr_only_flag", 32'(underrun), 32'd0);
    check("clr_only_cnt", 32'(underrun_cnt), 32'd0);

    // Saturation
    repeat (65540) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("sat_cnt", 32'(underrun_cnt), 32'hFFFF);

    // Queue 100 words, then drop en together with tx_ce
    repeat (101) drive(1'b1, 32'hFA5C_F123, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("pre_drop_I", 32'(tx_I), 32'h123);
    check("pre_drop_Q", 32'(tx_Q), 32'hA5C);
    check("pre_drop_level", 32'(fifo_level), 32'd100);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drop_level", 32'(fifo_level), 32'd0);
    check("drop_I", 32'(tx_I), 32'd0);
    check("drop_Q", 32'(tx_Q), 32'd0);
    check("drop_tready", 32'(s_tready), 32'd0);
    check("drop_running", 32'(running), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("reen_tready", 32'(s_tready), 32'd1);
    check("reen_level", 32'(fifo_level), 32'd0);
    repeat (600) rnd_cycle(70, 30, 1);

    // Reset mid-run
    rst = 1'b1;
    drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    check("mrst_I", 32'(tx_I), 32'd0);
    check("mrst_Q", 32'(tx_Q), 32'd0);
    check("mrst_tready", 32'(s_tready), 32'd0);
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_running", 32'(running), 32'd0);
    check("mrst_ur", 32'(underrun), 32'd0);
    check("mrst_cnt", 32'(underrun_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("post_rst_prime", 32'(s_tready), 32'd1);
    repeat (100) rnd_cycle(50, 50, 0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
